// File: rtl/select_merge_sync.sv
// Two-channel 2-phase merge: synchronizes both requests and the downstream ack,
// grants one channel at a time onto out_req/out_sel, and round-robins on contention.
module select_merge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic true_req,
  output logic true_ack,
  input  logic false_req,
  output logic false_ack,
  output logic out_req,
  output logic out_sel,
  input  logic out_ack
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] treq_sync_q, freq_sync_q, oack_sync_q;

  logic true_ack_q, true_ack_d;
  logic false_ack_q, false_ack_d;
  logic out_req_q, out_req_d;
  logic out_sel_q, out_sel_d;
  logic grant_q, grant_d;          // 1 = current transfer belongs to the true channel
  logic last_grant_q, last_grant_d; // 1 = true channel completed most recently

  logic true_req_s, false_req_s, out_ack_s;
  logic pending_t, pending_f, any_pending, grant_true, ack_done;

  assign true_req_s  = treq_sync_q[SYNC_STAGES-1];
  assign false_req_s = freq_sync_q[SYNC_STAGES-1];
  assign out_ack_s   = oack_sync_q[SYNC_STAGES-1];

  assign pending_t   = true_req_s ^ true_ack_q;
  assign pending_f   = false_req_s ^ false_ack_q;
  assign any_pending = pending_t | pending_f;
  // On contention the channel that did not complete last wins.
  assign grant_true  = pending_t & (~pending_f | ~last_grant_q);
  assign ack_done    = (out_ack_s == out_req_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      treq_sync_q  <= '0;
      freq_sync_q  <= '0;
      oack_sync_q  <= '0;
      state_q      <= IDLE;
      true_ack_q   <= 1'b0;
      false_ack_q  <= 1'b0;
      out_req_q    <= 1'b0;
      out_sel_q    <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
    end else begin
      treq_sync_q  <= {treq_sync_q[SYNC_STAGES-2:0], true_req};
      freq_sync_q  <= {freq_sync_q[SYNC_STAGES-2:0], false_req};
      oack_sync_q  <= {oack_sync_q[SYNC_STAGES-2:0], out_ack};
      state_q      <= state_d;
      true_ack_q   <= true_ack_d;
      false_ack_q  <= false_ack_d;
      out_req_q    <= out_req_d;
      out_sel_q    <= out_sel_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (any_pending) state_d = WAIT_ACK;
      WAIT_ACK: if (ack_done)    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    true_ack_d   = true_ack_q;
    false_ack_d  = false_ack_q;
    out_req_d    = out_req_q;
    out_sel_d    = out_sel_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (any_pending) begin
          out_req_d = ~out_req_q;
          out_sel_d = grant_true;
          grant_d   = grant_true;
        end
      end
      WAIT_ACK: begin
        if (ack_done) begin
          if (grant_q) true_ack_d  = ~true_ack_q;
          else         false_ack_d = ~false_ack_q;
          last_grant_d = grant_q;
        end
      end
      default: ;
    endcase
  end

  assign true_ack  = true_ack_q;
  assign false_ack = false_ack_q;
  assign out_req   = out_req_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_select_merge_sync.sv
// Bench for select_merge_sync: directed latency/arbitration vectors, reset cases,
// and a random 2-phase stress run watched by an event-level protocol model.
module tb_select_merge_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic true_req = 1'b0, false_req = 1'b0, out_ack = 1'b0;
  logic true_ack, false_ack, out_req, out_sel;

  select_merge_sync #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .true_req(true_req), .true_ack(true_ack),
    .false_req(false_req), .false_ack(false_ack),
    .out_req(out_req), .out_sel(out_sel), .out_ack(out_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int resp_delay = 0, resp_cnt = 0;
  bit rand_delay = 1'b0;
  // Event-level model state: requests issued, grants seen, one outstanding transfer.
  int r_t = 0, r_f = 0, g_t = 0, g_f = 0;
  logic busy = 1'b0, gch = 1'b0;
  logic p_req = 1'b0, p_sel = 1'b0, p_tack = 1'b0, p_fack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic tog_t();
    true_req = ~true_req;
    r_t++;
  endtask

  task automatic tog_f();
    false_req = ~false_req;
    r_f++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    true_req = 1'b0;
    false_req = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // Downstream responder: mirrors out_req onto out_ack after resp_delay cycles.
  always @(negedge clk) begin
    if (rst) begin
      out_ack = 1'b0;
      resp_cnt = 0;
    end else if (out_req !== out_ack) begin
      if (resp_cnt >= resp_delay) begin
        out_ack = out_req;
        resp_cnt = 0;
        if (rand_delay) resp_delay = $urandom_range(0, 15);
      end else begin
        resp_cnt++;
      end
    end
  end

  // Protocol model checked every cycle: out_sel only moves with out_req, one transfer
  // at a time, every grant backed by an issued event, and each ack on the granted channel.
  always @(posedge clk) begin
    #3;
    if (rst) begin
      busy = 1'b0;
      r_t = 0; r_f = 0; g_t = 0; g_f = 0;
    end else begin
      if (out_req === p_req) begin
        chk("sel_stable", out_sel, p_sel);
      end else begin
        chk("grant_while_busy", busy, 0);
        busy = 1'b1;
        gch = out_sel;
        if (out_sel) begin
          g_t++;
          chk("grant_true_has_event", (g_t <= r_t), 1);
        end else begin
          g_f++;
          chk("grant_false_has_event", (g_f <= r_f), 1);
        end
      end
      if (true_ack !== p_tack || false_ack !== p_fack) begin
        chk("double_ack", (true_ack !== p_tack) && (false_ack !== p_fack), 0);
        chk("ack_owner", busy && (gch == (true_ack !== p_tack)), 1);
        busy = 1'b0;
      end
    end
    p_req = out_req; p_sel = out_sel; p_tack = true_ack; p_fack = false_ack;
  end

  initial begin
    int t0, t1, ntog, issued, guard;
    logic pr, sel1, sel2;

    // Reset with arbitrary request levels.
    true_req = 1'(($urandom) & 1);
    false_req = 1'b1;
    step(2);
    chk("rst_true_ack", true_ack, 0);
    chk("rst_false_ack", false_ack, 0);
    chk("rst_out_req", out_req, 0);
    chk("rst_out_sel", out_sel, 0);
    true_req = 1'b0;
    false_req = 1'b0;
    step(1);
    rst = 1'b0;
    step(3);

    // Single true event, immediate responder: out_req at E3, true_ack at F3.
    tog_t();
    step(2);
    chk("single_req_before_E3", out_req, 0);
    step(1);
    chk("single_req_at_E3", out_req, 1);
    chk("single_sel", out_sel, 1);
    step(2);
    chk("single_ack_before_F3", true_ack, 0);
    step(1);
    chk("single_ack_at_F3", true_ack, 1);
    chk("single_false_ack", false_ack, 0);
    step(3);

    // Simultaneous pair after reset: true first, false on the next IDLE cycle.
    do_reset();
    step(3);
    tog_t(); tog_f();
    step(3);
    chk("pair1_first_req", out_req, 1);
    chk("pair1_first_sel", out_sel, 1);
    step(4);
    chk("pair1_second_req", out_req, 0);
    chk("pair1_second_sel", out_sel, 0);
    step(3);
    chk("pair1_false_ack", false_ack, 1);
    chk("pair1_true_ack", true_ack, 1);
    step(3);
    // Lone true event makes true the most recent completion.
    tog_t();
    step(6);
    chk("lone_true_ack", true_ack, 0);
    step(2);
    // Contended pair now goes to false first.
    tog_t(); tog_f();
    step(3);
    chk("pair2_first_req", out_req, 0);
    chk("pair2_first_sel", out_sel, 0);
    step(3);
    chk("pair2_false_ack", false_ack, 0);
    chk("pair2_true_ack_pending", true_ack, 0);
    step(1);
    chk("pair2_second_req", out_req, 1);
    chk("pair2_second_sel", out_sel, 1);
    step(3);
    chk("pair2_true_ack", true_ack, 1);
    step(3);

    // Slow responder: false arrives mid-transfer and is granted only after true completes.
    resp_delay = 20;
    tog_t();
    t0 = -1; t1 = -1; ntog = 0; pr = out_req; sel1 = 1'b0; sel2 = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      step(1);
      if (out_req !== pr) begin
        ntog++;
        if (ntog == 1) begin t0 = k; sel1 = out_sel; end
        else if (ntog == 2) begin t1 = k; sel2 = out_sel; end
        pr = out_req;
      end
      if (k == 5) tog_f();
    end
    chk("slow_first_toggle_cycle", t0, 3);
    chk("slow_first_sel", sel1, 1);
    chk("slow_second_toggle_cycle", t1, 27);
    chk("slow_second_sel", sel2, 0);
    chk("slow_toggle_count", ntog, 2);
    chk("slow_true_ack", true_ack, 0);
    chk("slow_false_ack", false_ack, 1);
    step(2);

    // Reset during WAIT_ACK abandons the transfer; the next event runs normally.
    tog_t();
    step(6);
    do_reset();
    chk("midrst_out_req", out_req, 0);
    chk("midrst_out_sel", out_sel, 0);
    chk("midrst_true_ack", true_ack, 0);
    chk("midrst_false_ack", false_ack, 0);
    resp_delay = 0;
    step(3);
    tog_t();
    step(3);
    chk("postrst_req", out_req, 1);
    chk("postrst_sel", out_sel, 1);
    step(3);
    chk("postrst_ack", true_ack, 1);
    step(3);

    // Random stress with a random-delay responder.
    rand_delay = 1'b1;
    resp_delay = $urandom_range(0, 15);
    do_reset();
    step(3);
    issued = 0;
    guard = 0;
    while (issued < 1000 && guard < 60000) begin
      step(1);
      guard++;
      if (true_req === true_ack && $urandom_range(0, 3) == 0 && issued < 1000) begin
        tog_t();
        issued++;
      end
      if (false_req === false_ack && $urandom_range(0, 3) == 0 && issued < 1000) begin
        tog_f();
        issued++;
      end
    end
    chk("stress_issue_budget", (guard < 60000), 1);
    guard = 0;
    while (!(true_req === true_ack && false_req === false_ack && out_req === out_ack)
           && guard < 2000) begin
      step(1);
      guard++;
    end
    chk("stress_drained", (guard < 2000), 1);
    step(2);
    chk("stress_true_grants", g_t, r_t);
    chk("stress_false_grants", g_f, r_f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/select_merge_sync.md
SELECT_MERGE_SYNC -- requirements
Module: select_merge_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on each asynchronous input (legal range 2..4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port true_req  input  1  2-phase request, "true" channel (asynchronous to clk).
REQ-005 SHALL have port true_ack  output  1  2-phase acknowledge, "true" channel.
REQ-006 SHALL have port false_req  input  1  2-phase request, "false" channel (asynchronous to clk).
REQ-007 SHALL have port false_ack  output  1  2-phase acknowledge, "false" channel.
REQ-008 SHALL have port out_req  output  1  merged 2-phase request.
REQ-009 SHALL have port out_sel  output  1  bundled data: 1 = event came from true channel, 0 = from false channel.
REQ-010 SHALL have port out_ack  input  1  2-phase acknowledge for out_req (asynchronous to clk).
REQ-011 SHALL register every output directly from a flop; no combinational path from input to output.

Function
REQ-012 SHALL pass true_req, false_req and out_ack each through a SYNC_STAGES-deep flop chain; the FSM uses only the last-stage values (true_req_s, false_req_s, out_ack_s).
REQ-013 SHALL define pending_t = true_req_s XOR true_ack and pending_f = false_req_s XOR false_ack.
REQ-014 SHALL implement FSM with states IDLE and WAIT_ACK, encoded in a registered state variable.
REQ-015 In IDLE with exactly one of pending_t/pending_f set, SHALL grant that channel: out_sel <= 1 for true, 0 for false; out_req <= ~out_req; record granted channel; next state WAIT_ACK.
REQ-016 In IDLE with both pending, SHALL grant the channel not granted last (round-robin via 1-bit last_grant); after reset the true channel has priority.
REQ-017 In IDLE with neither pending, SHALL hold all outputs and stay in IDLE.
REQ-018 In WAIT_ACK, SHALL hold out_req and out_sel constant until out_ack_s == out_req.
REQ-019 On out_ack_s == out_req in WAIT_ACK, SHALL toggle the granted channel's ack (true_ack or false_ack), update last_grant, return to IDLE, all in that same edge.
REQ-020 SHALL never toggle out_req while in WAIT_ACK and never toggle both input acks in one cycle.
REQ-021 SHALL change out_sel only on the same edge that toggles out_req (bundled-data: out_sel stable one full cycle before, and throughout, each out_req phase relative to downstream sampling).
REQ-022 Latency (SYNC_STAGES=2): input req toggle captured at edge E1 -> out_req toggles at E3; out_ack toggle captured at edge F1 -> input ack toggles at F3; one cycle in IDLE between consecutive grants minimum, giving zero-gap-free throughput of one event per (2*SYNC_STAGES+2) cycles under an immediate responder.
REQ-023 A second pending channel arriving during WAIT_ACK SHALL be held and granted on the first IDLE cycle after completion; no event lost.
REQ-024 Protocol violation (req toggled twice before ack) is outside contract; block SHALL not deadlock, behaviour otherwise unspecified.

Reset
REQ-025 While rst=1 at a clk edge, SHALL set all synchronizer flops to 0, true_ack=0, false_ack=0, out_req=0, out_sel=0, last_grant=false (true priority next), state=IDLE.
REQ-026 Reset asserted mid-operation (WAIT_ACK) SHALL abandon the transfer; environment is required to return all req/ack lines to 0 together with rst.
REQ-027 First grant after reset release SHALL occur no earlier than SYNC_STAGES+1 edges after the first edge with rst=0.

Verification
REQ-028 Reset: rst=1 two cycles with arbitrary inputs -> all outputs 0, state IDLE.
REQ-029 Single true event: true_req 0->1, responder mirrors out_req to out_ack immediately -> out_sel=1, out_req 0->1 at E3, true_ack 0->1 at F3, false_ack stays 0.
REQ-030 Simultaneous: true_req and false_req toggle same cycle after reset -> true granted first (out_sel=1), then false (out_sel=0); second pair simultaneous -> false first (round-robin).
REQ-031 Slow responder: out_ack delayed 20 cycles, false_req toggles during WAIT_ACK -> out_req/out_sel frozen 20+ cycles, false event issued after true completes, exactly two out_req toggles total.
REQ-032 Reset mid-WAIT_ACK: rst pulsed with req/ack lines returned to 0 -> outputs 0, next true_req toggle processed normally.
REQ-033 Random stress: 1000 random 2-phase events on both channels, random responder delay 0..15 -> count of out_req toggles with out_sel=1 equals true_req toggles, same for false; no double-ack; out_sel never changes without out_req toggle.
